// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// Module  : execute_stage
// Brief   : Y86-64 E stage: E pipeline register, ALU, condition codes, Cnd.
// Revision: 1.0
// ============================================================================
module execute_stage #(
  parameter int         DATA_W   = 64,
  parameter logic [3:0] STAT_AOK = 4'h1,
  parameter logic [3:0] STAT_HLT = 4'h2,
  parameter logic [3:0] STAT_ADR = 4'h3,
  parameter logic [3:0] STAT_INS = 4'h4,
  parameter logic [3:0] RNONE    = 4'hF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              E_bubble,
  input  logic [3:0]        d_stat,
  input  logic [3:0]        d_icode,
  input  logic [3:0]        d_ifun,
  input  logic [DATA_W-1:0] d_valC,
  input  logic [DATA_W-1:0] d_valA,
  input  logic [DATA_W-1:0] d_valB,
  input  logic [3:0]        d_destE,
  input  logic [3:0]        d_destM,
  input  logic [3:0]        d_srcA,
  input  logic [3:0]        d_srcB,
  input  logic [3:0]        m_stat,
  input  logic [3:0]        W_stat,
  output logic [3:0]        E_stat,
  output logic [3:0]        E_icode,
  output logic [3:0]        E_ifun,
  output logic [DATA_W-1:0] E_valA,
  output logic [DATA_W-1:0] E_valC,
  output logic [3:0]        E_destM,
  output logic [3:0]        E_srcA,
  output logic [3:0]        E_srcB,
  output logic [DATA_W-1:0] e_valE,
  output logic [3:0]        e_destE,
  output logic              e_Cnd,
  output logic              zf,
  output logic              sf,
  output logic              of,
  output logic              g,
  output logic              ge,
  output logic              e,
  output logic              ne,
  output logic              le,
  output logic              l
);

  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_RRMOV = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_XOR = 2'd3;

  logic [DATA_W-1:0] E_valB;
  logic [3:0]        E_destE;

  // E pipeline register; bubble encoding matches the reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      E_stat  <= STAT_AOK;
      E_icode <= I_NOP;
      E_ifun  <= 4'h0;
      E_valA  <= '0;
      E_valB  <= '0;
      E_valC  <= '0;
      E_destE <= RNONE;
      E_destM <= RNONE;
      E_srcA  <= RNONE;
      E_srcB  <= RNONE;
    end else if (E_bubble) begin
      E_stat  <= STAT_AOK;
      E_icode <= I_NOP;
      E_ifun  <= 4'h0;
      E_valA  <= '0;
      E_valB  <= '0;
      E_valC  <= '0;
      E_destE <= RNONE;
      E_destM <= RNONE;
      E_srcA  <= RNONE;
      E_srcB  <= RNONE;
    end else begin
      E_stat  <= d_stat;
      E_icode <= d_icode;
      E_ifun  <= d_ifun;
      E_valA  <= d_valA;
      E_valB  <= d_valB;
      E_valC  <= d_valC;
      E_destE <= d_destE;
      E_destM <= d_destM;
      E_srcA  <= d_srcA;
      E_srcB  <= d_srcB;
    end
  end

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [1:0]        alu_op;
  logic [DATA_W-1:0] alu_res;
  logic              alu_zf;
  logic              alu_sf;
  logic              alu_of;

  always_comb begin
    alu_a = '0;
    case (E_icode)
      I_RRMOV, I_OPQ:          alu_a = E_valA;
      I_IRMOV, I_RMMOV, I_MRMOV: alu_a = E_valC;
      I_CALL, I_PUSH:          alu_a = {{(DATA_W-4){1'b1}}, 4'b1000};
      I_RET, I_POP:            alu_a = DATA_W'(8);
      default:                 alu_a = '0;
    endcase
  end

  always_comb begin
    alu_b = '0;
    case (E_icode)
      I_RMMOV, I_MRMOV, I_OPQ, I_CALL, I_RET, I_PUSH, I_POP: alu_b = E_valB;
      default:                                             alu_b = '0;
    endcase
  end

  always_comb begin
    alu_op = OP_ADD;
    if (E_icode == I_OPQ && E_ifun <= 4'd3) alu_op = E_ifun[1:0];
  end

  always_comb begin
    alu_res = '0;
    alu_of  = 1'b0;
    case (alu_op)
      OP_ADD: begin
        alu_res = alu_b + alu_a;
        alu_of  = (alu_a[DATA_W-1] == alu_b[DATA_W-1]) &&
                  (alu_res[DATA_W-1] != alu_a[DATA_W-1]);
      end
      OP_SUB: begin
        alu_res = alu_b - alu_a;
        alu_of  = (alu_b[DATA_W-1] != alu_a[DATA_W-1]) &&
                  (alu_res[DATA_W-1] != alu_b[DATA_W-1]);
      end
      OP_AND: alu_res = alu_b & alu_a;
      OP_XOR: alu_res = alu_b ^ alu_a;
      default: alu_res = '0;
    endcase
  end

  assign alu_zf = (alu_res == '0);
  assign alu_sf = alu_res[DATA_W-1];

  // Later-stage exceptions suppress CC writes so a faulting program leaves no trace.
  logic m_bad;
  logic w_bad;
  logic set_cc;
  assign m_bad  = (m_stat == STAT_ADR) || (m_stat == STAT_INS) || (m_stat == STAT_HLT);
  assign w_bad  = (W_stat == STAT_ADR) || (W_stat == STAT_INS) || (W_stat == STAT_HLT);
  assign set_cc = (E_icode == I_OPQ) && (E_ifun <= 4'd3) && (E_stat == STAT_AOK) &&
                  !m_bad && !w_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf <= 1'b1;
      sf <= 1'b0;
      of <= 1'b0;
    end else if (set_cc) begin
      zf <= alu_zf;
      sf <= alu_sf;
      of <= alu_of;
    end
  end

  function automatic logic cond_eval(input logic [3:0] fn, input logic z, input logic s,
                                     input logic o);
    case (fn)
      4'd0:    return 1'b1;
      4'd1:    return (s ^ o) | z;
      4'd2:    return s ^ o;
      4'd3:    return z;
      4'd4:    return ~z;
      4'd5:    return ~(s ^ o);
      4'd6:    return ~(s ^ o) & ~z;
      default: return 1'b0;
    endcase
  endfunction

  assign e_Cnd   = cond_eval(E_ifun, zf, sf, of);
  assign le      = cond_eval(4'd1, zf, sf, of);
  assign l       = cond_eval(4'd2, zf, sf, of);
  assign e       = cond_eval(4'd3, zf, sf, of);
  assign ne      = cond_eval(4'd4, zf, sf, of);
  assign ge      = cond_eval(4'd5, zf, sf, of);
  assign g       = cond_eval(4'd6, zf, sf, of);

  assign e_valE  = alu_res;
  assign e_destE = (E_icode == I_RRMOV && !e_Cnd) ? RNONE : E_destE;

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_execute_stage
// Brief   : Directed self-checking bench for execute_stage.
// Revision: 1.0
// ============================================================================
module tb_execute_stage;

  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              E_bubble;
  logic [3:0]        d_stat, d_icode, d_ifun;
  logic [DATA_W-1:0] d_valC, d_valA, d_valB;
  logic [3:0]        d_destE, d_destM, d_srcA, d_srcB;
  logic [3:0]        m_stat, W_stat;
  logic [3:0]        E_stat, E_icode, E_ifun;
  logic [DATA_W-1:0] E_valA, E_valC;
  logic [3:0]        E_destM, E_srcA, E_srcB;
  logic [DATA_W-1:0] e_valE;
  logic [3:0]        e_destE;
  logic              e_Cnd, zf, sf, of, g, ge, e, ne, le, l;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  execute_stage #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .E_bubble(E_bubble),
    .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun),
    .d_valC(d_valC), .d_valA(d_valA), .d_valB(d_valB),
    .d_destE(d_destE), .d_destM(d_destM), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .m_stat(m_stat), .W_stat(W_stat),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valA(E_valA), .E_valC(E_valC),
    .E_destM(E_destM), .E_srcA(E_srcA), .E_srcB(E_srcB),
    .e_valE(e_valE), .e_destE(e_destE), .e_Cnd(e_Cnd),
    .zf(zf), .sf(sf), .of(of),
    .g(g), .ge(ge), .e(e), .ne(ne), .le(le), .l(l)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // Present one instruction on d_*, clock it into E, then settle 1 time unit.
  task automatic load(input logic [3:0] icode, input logic [3:0] ifun,
                      input logic [63:0] va, input logic [63:0] vb,
                      input logic [63:0] vc, input logic [3:0] dste);
    d_stat  = 4'h1;
    d_icode = icode;
    d_ifun  = ifun;
    d_valA  = va;
    d_valB  = vb;
    d_valC  = vc;
    d_destE = dste;
    d_destM = 4'hF;
    d_srcA  = 4'h0;
    d_srcB  = 4'h1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    E_bubble = 1'b0;
    m_stat   = 4'h1;
    W_stat   = 4'h1;
    d_stat = 4'h1; d_icode = 4'h1; d_ifun = 4'h0;
    d_valA = '0; d_valB = '0; d_valC = '0;
    d_destE = 4'hF; d_destM = 4'hF; d_srcA = 4'hF; d_srcB = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    check("rst_icode", 64'(E_icode), 64'h1);
    check("rst_destE", 64'(e_destE), 64'hF);
    check("rst_zf",    64'(zf), 64'h1);
    check("rst_e",     64'(e), 64'h1);
    rst_n = 1'b1;

    // sub: 3 - 5
    load(4'h6, 4'h1, 64'd5, 64'd3, 64'd0, 4'h2);
    check("sub_valE",  e_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    check("sub_destE", 64'(e_destE), 64'h2);

    // cmove with flags from the sub
    load(4'h2, 4'h3, 64'd9, 64'd0, 64'd0, 4'h5);
    check("sub_sf", 64'(sf), 64'h1);
    check("sub_zf", 64'(zf), 64'h0);
    check("sub_of", 64'(of), 64'h0);
    check("sub_l",  64'(l),  64'h1);
    check("sub_ge", 64'(ge), 64'h0);
    check("cmove_valE",  e_valE, 64'd9);
    check("cmove_cnd",   64'(e_Cnd), 64'h0);
    check("cmove_destE", 64'(e_destE), 64'hF);

    load(4'h2, 4'h2, 64'd9, 64'd0, 64'd0, 4'h5);
    check("cmovl_cnd",   64'(e_Cnd), 64'h1);
    check("cmovl_destE", 64'(e_destE), 64'h5);

    // signed overflow on add
    load(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h3);
    check("add_valE", e_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    load(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF);
    check("add_of", 64'(of), 64'h1);
    check("add_sf", 64'(sf), 64'h1);
    check("add_l",  64'(l),  64'h0);
    check("add_ge", 64'(ge), 64'h1);
    check("add_g",  64'(g),  64'h1);

    // stack pointer arithmetic
    load(4'hA, 4'h0, 64'h55, 64'h100, 64'd0, 4'h4);
    check("push_valE",  e_valE, 64'hF8);
    check("push_destE", 64'(e_destE), 64'h4);
    check("push_valA",  E_valA, 64'h55);
    load(4'hB, 4'h0, 64'd0, 64'h100, 64'd0, 4'h4);
    check("pop_valE", e_valE, 64'h108);
    load(4'h3, 4'h0, 64'd0, 64'd0, 64'h1234, 4'h6);
    check("irmov_valE", e_valE, 64'h1234);
    check("irmov_valC", E_valC, 64'h1234);

    // xor gated by m_stat=ADR: CC must stay (zf=0 sf=1 of=1)
    load(4'h6, 4'h3, 64'd5, 64'd5, 64'd0, 4'h2);
    m_stat = 4'h3;
    check("xor_valE", e_valE, 64'd0);
    load(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF);
    check("gate_m_zf", 64'(zf), 64'h0);
    check("gate_m_of", 64'(of), 64'h1);
    m_stat = 4'h1;

    // same xor gated by W_stat=HLT
    load(4'h6, 4'h3, 64'd5, 64'd5, 64'd0, 4'h2);
    W_stat = 4'h2;
    load(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF);
    check("gate_w_zf", 64'(zf), 64'h0);
    W_stat = 4'h1;

    // ungated xor updates CC
    load(4'h6, 4'h3, 64'd5, 64'd5, 64'd0, 4'h2);
    load(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF);
    check("xor_zf", 64'(zf), 64'h1);
    check("xor_of", 64'(of), 64'h0);
    check("xor_sf", 64'(sf), 64'h0);

    // bubble with set_cc in the outgoing instruction: both take effect
    load(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h2);
    check("add2_valE", e_valE, 64'd2);
    E_bubble = 1'b1;
    load(4'h6, 4'h0, 64'd7, 64'd7, 64'd0, 4'h7);
    E_bubble = 1'b0;
    check("bub_icode", 64'(E_icode), 64'h1);
    check("bub_destM", 64'(E_destM), 64'hF);
    check("bub_destE", 64'(e_destE), 64'hF);
    check("bub_srcA",  64'(E_srcA),  64'hF);
    check("bub_valE",  e_valE, 64'd0);
    check("bub_cc_zf", 64'(zf), 64'h0);

    // ifun > 3 computes add and does not touch CC
    load(4'h6, 4'h5, 64'd4, 64'd6, 64'd0, 4'h2);
    check("opq5_valE", e_valE, 64'd10);
    load(4'h6, 4'h2, 64'h0F0, 64'h0FF, 64'd0, 4'h2);
    check("opq5_zf", 64'(zf), 64'h0);
    check("and_valE", e_valE, 64'h0F0);

    // async reset mid-cycle while E holds an OPq
    load(4'h6, 4'h1, 64'd5, 64'd3, 64'd0, 4'h2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_icode", 64'(E_icode), 64'h1);
    check("arst_destE", 64'(e_destE), 64'hF);
    check("arst_zf", 64'(zf), 64'h1);
    check("arst_sf", 64'(sf), 64'h0);
    check("arst_of", 64'(of), 64'h0);
    check("arst_e",  64'(e),  64'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
